// File: rtl/coil_pkg.sv
// ---------------------------------------------------------------------------
// coil_pkg
// Shared definitions for the MRI coil H-bridge path: drive state encoding,
// metadata word field positions and code widths. The upstream link decoder
// imports the same field positions so both ends agree on the CONFIG layout.
// ---------------------------------------------------------------------------
package coil_pkg;

    // Drive sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEAD      = 3'd1,
        ST_DRIVE_POS = 3'd2,
        ST_DRIVE_NEG = 3'd3,
        ST_FAULT     = 3'd4
    } coil_state_e;

    // Metadata word layout.
    localparam int CFG_W       = 4;
    localparam int AMP_W       = 2;
    localparam int WD_CODE_W   = 2;
    localparam int CFG_AMP_LSB = 0;
    localparam int CFG_WD_LSB  = 2;

    // Packed view of the metadata word; field order matches the LSB
    // positions above (watchdog code in [3:2], amplitude code in [1:0]).
    typedef struct packed {
        logic [WD_CODE_W-1:0] wd_code;
        logic [AMP_W-1:0]     amp;
    } coil_cfg_t;

    // One bit per bridge gate.
    typedef struct packed {
        logic hs_p;
        logic ls_p;
        logic hs_n;
        logic ls_n;
    } coil_gates_t;

    localparam coil_gates_t GATES_OFF = '0;

endpackage

// File: rtl/coil_hbridge_driver_if.sv
// ---------------------------------------------------------------------------
// coil_hbridge_driver_if
// Link between the decoder side and the H-bridge driver.
//   SCAN_ACTIVE_IN   decoder is in its scan phase
//   POLARITY_IN      1 = SendPos, 0 = SendNeg
//   CONFIG_IN        metadata word ([1:0] amplitude, [3:2] watchdog code)
//   CONFIG_VALID_IN  one-cycle strobe qualifying CONFIG_IN
//   HS_P_OUT/LS_P_OUT/HS_N_OUT/LS_N_OUT  bridge gate drives
//   DRIVE_BUSY_OUT   driver not idle
//   FAULT_OUT        sticky watchdog fault
// master: decoder side (drives requests, observes gates/status)
// slave : driver side
// ---------------------------------------------------------------------------
interface coil_hbridge_driver_if;

    logic                      SCAN_ACTIVE_IN;
    logic                      POLARITY_IN;
    logic [coil_pkg::CFG_W-1:0] CONFIG_IN;
    logic                      CONFIG_VALID_IN;
    logic                      HS_P_OUT;
    logic                      LS_P_OUT;
    logic                      HS_N_OUT;
    logic                      LS_N_OUT;
    logic                      DRIVE_BUSY_OUT;
    logic                      FAULT_OUT;

    modport master (
        output SCAN_ACTIVE_IN, POLARITY_IN, CONFIG_IN, CONFIG_VALID_IN,
        input  HS_P_OUT, LS_P_OUT, HS_N_OUT, LS_N_OUT, DRIVE_BUSY_OUT, FAULT_OUT
    );

    modport slave (
        input  SCAN_ACTIVE_IN, POLARITY_IN, CONFIG_IN, CONFIG_VALID_IN,
        output HS_P_OUT, LS_P_OUT, HS_N_OUT, LS_N_OUT, DRIVE_BUSY_OUT, FAULT_OUT
    );

endinterface

// File: rtl/coil_pwm_gen.sv
// ---------------------------------------------------------------------------
// coil_pwm_gen
// Free-running PWM frame counter with synchronous clear and duty compare.
//   CLK_IN, RST_N_IN  clock, async active-low reset
//   clear             next count is forced to 0 (frame restart)
//   duty              high-time in clocks, 0..PWM_PERIOD
//   pwm_on            compare result for the count the counter is about to
//                     take, so a caller registering it lines the gate up with
//                     that count (count 0 -> first clock of a frame)
// ---------------------------------------------------------------------------
module coil_pwm_gen #(
    parameter int PWM_PERIOD = 64,
    parameter int CNT_W      = $clog2(PWM_PERIOD),
    parameter int DUTY_W     = $clog2(PWM_PERIOD + 1)
) (
    input  logic              CLK_IN,
    input  logic              RST_N_IN,
    input  logic              clear,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_on
);

    logic [CNT_W-1:0] pwm_cnt_q;
    logic [CNT_W-1:0] pwm_cnt_d;

    always_comb begin
        if (clear || pwm_cnt_q == CNT_W'(PWM_PERIOD - 1)) begin
            pwm_cnt_d = '0;
        end else begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
        end
    end

    assign pwm_on = DUTY_W'(pwm_cnt_d) < duty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

endmodule

// File: rtl/coil_hbridge_driver.sv
// ---------------------------------------------------------------------------
// coil_hbridge_driver
// Drives the four gates of the MRI coil H-bridge from the decoder's scan
// polarity. Break-before-make dead time on every direction change, high-side
// PWM for amplitude, sticky watchdog fault when one polarity is held too long.
//   CLK_IN    system clock
//   RST_N_IN  asynchronous active-low reset
//   bus       coil_hbridge_driver_if.slave (requests in, gates/status out)
// All outputs are registered.
// ---------------------------------------------------------------------------
module coil_hbridge_driver
    import coil_pkg::*;
#(
    parameter int DEAD_CYCLES    = 8,
    parameter int PWM_PERIOD     = 64,
    parameter int WD_BASE_CYCLES = 1000
) (
    input  logic                 CLK_IN,
    input  logic                 RST_N_IN,
    coil_hbridge_driver_if.slave bus
);

    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int DUTY_W = $clog2(PWM_PERIOD + 1);
    localparam int WD_W   = $clog2(4 * WD_BASE_CYCLES + 1);

    coil_state_e       state_q;
    coil_state_e       state_d;
    coil_cfg_t         cfg_q;
    logic [DEAD_W-1:0] dead_cnt_q;
    logic [WD_W-1:0]   wd_cnt_q;
    logic [WD_W-1:0]   wd_next;
    logic [WD_W-1:0]   wd_limit;
    logic [DUTY_W-1:0] duty;
    logic              in_drive;
    logic              stay_drive;
    logic              pwm_on;
    coil_gates_t       gates_d;
    coil_gates_t       gates_q;

    assign duty     = DUTY_W'((int'(cfg_q.amp) + 1) * (PWM_PERIOD / 4));
    assign wd_limit = WD_W'(WD_BASE_CYCLES * (int'(cfg_q.wd_code) + 1));
    assign wd_next  = wd_cnt_q + 1'b1;

    assign in_drive   = (state_q == ST_DRIVE_POS) || (state_q == ST_DRIVE_NEG);
    assign stay_drive = in_drive && (state_d == state_q);

    // Any entry into a drive state restarts the frame, so the first drive
    // clock always falls in the high part of the duty cycle.
    coil_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD)
    ) u_pwm (
        .CLK_IN   (CLK_IN),
        .RST_N_IN (RST_N_IN),
        .clear    (!stay_drive),
        .duty     (duty),
        .pwm_on   (pwm_on)
    );

    // Next-state: scan drop beats watchdog expiry, which beats a polarity
    // change.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.SCAN_ACTIVE_IN) state_d = ST_DEAD;
            end
            ST_DEAD: begin
                if (!bus.SCAN_ACTIVE_IN) begin
                    state_d = ST_IDLE;
                end else if (dead_cnt_q == DEAD_W'(DEAD_CYCLES - 1)) begin
                    // Only the polarity present at dead-time exit counts.
                    state_d = bus.POLARITY_IN ? ST_DRIVE_POS : ST_DRIVE_NEG;
                end
            end
            ST_DRIVE_POS: begin
                if (!bus.SCAN_ACTIVE_IN)     state_d = ST_IDLE;
                else if (wd_next == wd_limit) state_d = ST_FAULT;
                else if (!bus.POLARITY_IN)    state_d = ST_DEAD;
            end
            ST_DRIVE_NEG: begin
                if (!bus.SCAN_ACTIVE_IN)     state_d = ST_IDLE;
                else if (wd_next == wd_limit) state_d = ST_FAULT;
                else if (bus.POLARITY_IN)     state_d = ST_DEAD;
            end
            ST_FAULT: begin
                if (!bus.SCAN_ACTIVE_IN) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gates are decoded from the next state so the registered outputs change
    // on the same edge as the state; leaving a drive state therefore turns
    // the bridge off on that very edge.
    always_comb begin
        gates_d = GATES_OFF;
        case (state_d)
            ST_DRIVE_POS: begin
                gates_d.ls_n = 1'b1;
                gates_d.hs_p = pwm_on;
            end
            ST_DRIVE_NEG: begin
                gates_d.ls_p = 1'b1;
                gates_d.hs_n = pwm_on;
            end
            default: gates_d = GATES_OFF;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            state_q            <= ST_IDLE;
            cfg_q              <= '0;
            dead_cnt_q         <= '0;
            wd_cnt_q           <= '0;
            gates_q            <= GATES_OFF;
            bus.DRIVE_BUSY_OUT <= 1'b0;
            bus.FAULT_OUT      <= 1'b0;
        end else begin
            state_q <= state_d;

            // Metadata is only accepted between scans.
            if (state_q == ST_IDLE && bus.CONFIG_VALID_IN) begin
                cfg_q <= coil_cfg_t'(bus.CONFIG_IN);
            end

            // Both counters run only while their state persists and restart
            // from 0 on every entry.
            dead_cnt_q <= (state_q == ST_DEAD && state_d == ST_DEAD) ?
                          dead_cnt_q + 1'b1 : '0;
            wd_cnt_q   <= stay_drive ? wd_next : '0;

            gates_q            <= gates_d;
            bus.DRIVE_BUSY_OUT <= (state_d != ST_IDLE);
            bus.FAULT_OUT      <= (state_d == ST_FAULT);
        end
    end

    assign bus.HS_P_OUT = gates_q.hs_p;
    assign bus.LS_P_OUT = gates_q.ls_p;
    assign bus.HS_N_OUT = gates_q.hs_n;
    assign bus.LS_N_OUT = gates_q.ls_n;

endmodule

// File: tb/tb_coil_hbridge_driver.sv
// ---------------------------------------------------------------------------
// tb_coil_hbridge_driver
// Directed bench for coil_hbridge_driver with default parameters
// (DEAD_CYCLES=8, PWM_PERIOD=64, WD_BASE_CYCLES=1000). Gate patterns are
// shown as {HS_P, LS_P, HS_N, LS_N}: positive drive = 4'b1001 (PWM on),
// negative drive = 4'b0110 (PWM on).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_coil_hbridge_driver;

    localparam int DEAD = 8;
    localparam logic [3:0] POS_ON = 4'b1001;
    localparam logic [3:0] NEG_ON = 4'b0110;

    logic CLK_IN;
    logic RST_N_IN;

    coil_hbridge_driver_if bus ();

    coil_hbridge_driver #(
        .DEAD_CYCLES    (8),
        .PWM_PERIOD     (64),
        .WD_BASE_CYCLES (1000)
    ) dut (
        .CLK_IN   (CLK_IN),
        .RST_N_IN (RST_N_IN),
        .bus      (bus)
    );

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] gates();
        return {bus.HS_P_OUT, bus.LS_P_OUT, bus.HS_N_OUT, bus.LS_N_OUT};
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic load_cfg(input logic [3:0] c);
        bus.CONFIG_IN       = c;
        bus.CONFIG_VALID_IN = 1'b1;
        step();
        bus.CONFIG_VALID_IN = 1'b0;
    endtask

    // Step until gates turn on; returns the number of all-off samples seen.
    task automatic wait_on(input int limit, output int n_off);
        n_off = 0;
        while (n_off < limit) begin
            step();
            if (gates() != 4'b0000) break;
            n_off++;
        end
    endtask

    // Sample the current cycle then advance, n times.
    task automatic count_win(input int n, output int hp, output int hn,
                             output int lp, output int ln);
        hp = 0; hn = 0; lp = 0; ln = 0;
        for (int i = 0; i < n; i++) begin
            hp += int'(bus.HS_P_OUT);
            hn += int'(bus.HS_N_OUT);
            lp += int'(bus.LS_P_OUT);
            ln += int'(bus.LS_N_OUT);
            step();
        end
    endtask

    // Count consecutive samples with any gate on, bounded.
    task automatic count_on(input int limit, output int n_on);
        n_on = 0;
        while (gates() != 4'b0000 && n_on < limit) begin
            n_on++;
            step();
        end
    endtask

    // Safety monitor: shoot-through combinations and dead gap between legs.
    int mon_gap      = 0;
    int mon_last_leg = 0;
    always @(negedge CLK_IN) begin
        int leg;
        check("no_hsp_lsp", {31'd0, bus.HS_P_OUT & bus.LS_P_OUT}, 0);
        check("no_hsn_lsn", {31'd0, bus.HS_N_OUT & bus.LS_N_OUT}, 0);
        check("no_hsp_hsn", {31'd0, bus.HS_P_OUT & bus.HS_N_OUT}, 0);
        if (!RST_N_IN) begin
            mon_last_leg = 0;
            mon_gap      = 0;
        end else begin
            leg = (bus.HS_P_OUT || bus.LS_N_OUT) ? 1 :
                  (bus.HS_N_OUT || bus.LS_P_OUT) ? 2 : 0;
            if (leg == 0) begin
                mon_gap++;
            end else begin
                if (mon_last_leg != 0 && leg != mon_last_leg)
                    check("dead_gap_ok", {31'd0, mon_gap >= DEAD}, 1);
                mon_last_leg = leg;
                mon_gap      = 0;
            end
        end
    end

    initial begin
        int n_off, n_on, hp, hn, lp, ln, hp2, hn2, lp2, ln2;

        RST_N_IN            = 1'b0;
        bus.SCAN_ACTIVE_IN  = 1'b0;
        bus.POLARITY_IN     = 1'b0;
        bus.CONFIG_IN       = 4'b0000;
        bus.CONFIG_VALID_IN = 1'b0;

        // Reset state.
        repeat (3) step();
        check("rst_gates", gates(), 0);
        check("rst_busy", bus.DRIVE_BUSY_OUT, 0);
        check("rst_fault", bus.FAULT_OUT, 0);
        @(negedge CLK_IN);
        RST_N_IN = 1'b1;
        step();

        // Basic drive at 100% duty: 8 off clocks, then 1001 continuously.
        load_cfg(4'b0011);
        bus.POLARITY_IN    = 1'b1;
        bus.SCAN_ACTIVE_IN = 1'b1;
        wait_on(40, n_off);
        check("basic_dead_cnt", n_off, DEAD);
        check("basic_pattern", gates(), POS_ON);
        check("basic_busy", bus.DRIVE_BUSY_OUT, 1);
        count_win(64, hp, hn, lp, ln);
        check("basic_hsp_full", hp, 64);
        check("basic_lsn_full", ln, 64);

        // Scan drop returns to idle with gates off next clock.
        bus.SCAN_ACTIVE_IN = 1'b0;
        step();
        check("idle_gates", gates(), 0);
        check("idle_busy", bus.DRIVE_BUSY_OUT, 0);

        // PWM duty amp=1 -> 32 of 64, first drive clock high.
        load_cfg(4'b0001);
        bus.SCAN_ACTIVE_IN = 1'b1;
        wait_on(40, n_off);
        check("pwm_dead_cnt", n_off, DEAD);
        check("pwm_first_hs", bus.HS_P_OUT, 1);
        count_win(64, hp, hn, lp, ln);
        check("pwm_hsp_32", hp, 32);
        check("pwm_lsn_64", ln, 64);
        check("pwm_other_off", hn + lp, 0);

        // Config strobe during drive is ignored: duty stays 32/64.
        bus.CONFIG_IN       = 4'b1111;
        bus.CONFIG_VALID_IN = 1'b1;
        count_win(1, hp, hn, lp, ln);
        bus.CONFIG_VALID_IN = 1'b0;
        count_win(63, hp2, hn2, lp2, ln2);
        check("cfg_ignored_duty", hp + hp2, 32);

        // Direction change 1->0: 8 off clocks then negative leg PWM.
        bus.POLARITY_IN = 1'b0;
        wait_on(40, n_off);
        check("dir_dead_cnt", n_off, DEAD);
        check("dir_neg_pattern", gates(), NEG_ON);
        count_win(64, hp, hn, lp, ln);
        check("dir_hsn_32", hn, 32);
        check("dir_lsp_64", lp, 64);

        // Toggle during DEAD; exit value (1) decides -> positive.
        bus.POLARITY_IN = 1'b1;
        step();
        bus.POLARITY_IN = 1'b0;
        step();
        step();
        bus.POLARITY_IN = 1'b1;
        wait_on(40, n_off);
        check("tog_dead_cnt", n_off + 3, DEAD);
        check("tog_pos_pattern", gates(), POS_ON);

        // Toggle during DEAD; exit value (0) decides -> negative.
        bus.POLARITY_IN = 1'b0;
        step();
        bus.POLARITY_IN = 1'b1;
        step();
        bus.POLARITY_IN = 1'b0;
        wait_on(40, n_off);
        check("tog2_dead_cnt", n_off + 2, DEAD);
        check("tog2_neg_pattern", gates(), NEG_ON);

        // Scan drop during DEAD goes straight to idle.
        bus.POLARITY_IN = 1'b1;
        step();
        step();
        bus.SCAN_ACTIVE_IN = 1'b0;
        step();
        check("dead_abort_busy", bus.DRIVE_BUSY_OUT, 0);
        check("dead_abort_gates", gates(), 0);

        // Strobe in idle is latched: amp=3, wd=3 -> full duty, 4000 limit.
        load_cfg(4'b1111);
        bus.SCAN_ACTIVE_IN = 1'b1;
        wait_on(40, n_off);
        count_on(5000, n_on);
        check("wd3_on_clocks", n_on, 4000);
        check("wd3_fault", bus.FAULT_OUT, 1);
        bus.SCAN_ACTIVE_IN = 1'b0;
        step();
        check("wd3_clear", bus.FAULT_OUT, 0);

        // Watchdog wd=0: FAULT after 1000 drive clocks, sticky until scan drops.
        load_cfg(4'b0011);
        bus.SCAN_ACTIVE_IN = 1'b1;
        wait_on(40, n_off);
        count_on(1200, n_on);
        check("wd_on_clocks", n_on, 1000);
        check("wd_gates_off", gates(), 0);
        check("wd_fault", bus.FAULT_OUT, 1);
        check("wd_busy", bus.DRIVE_BUSY_OUT, 1);
        repeat (20) step();
        check("wd_sticky_fault", bus.FAULT_OUT, 1);
        check("wd_sticky_gates", gates(), 0);
        bus.SCAN_ACTIVE_IN = 1'b0;
        step();
        check("wd_exit_fault", bus.FAULT_OUT, 0);
        check("wd_exit_busy", bus.DRIVE_BUSY_OUT, 0);

        // Reset mid-drive: gates drop asynchronously, config returns to 0.
        bus.SCAN_ACTIVE_IN = 1'b1;
        wait_on(40, n_off);
        check("pre_rst_pattern", gates(), POS_ON);
        #3;
        RST_N_IN = 1'b0;
        #1;
        check("async_rst_gates", gates(), 0);
        check("async_rst_fault", bus.FAULT_OUT, 0);
        check("async_rst_busy", bus.DRIVE_BUSY_OUT, 0);
        bus.SCAN_ACTIVE_IN = 1'b0;
        @(negedge CLK_IN);
        RST_N_IN = 1'b1;
        step();
        bus.SCAN_ACTIVE_IN = 1'b1;
        wait_on(40, n_off);
        count_win(64, hp, hn, lp, ln);
        check("post_rst_duty16", hp, 16);
        bus.SCAN_ACTIVE_IN = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coil_hbridge_driver.md
Name: coil_hbridge_driver

Overview:
- Downstream stage of the DATA_IN link decoder FSM: consumes its scan-phase polarity (SendPos/SendNeg) and its 4-bit metadata word, and drives the four gates of the MRI coil H-bridge.
- Inserts break-before-make dead time on every direction change.
- PWMs the high side for amplitude control.
- Trips a sticky fault if one polarity is held past a watchdog limit.

Parameters:
- DEAD_CYCLES, 8, clocks with all gates off between any two drive directions (min 1).
- PWM_PERIOD, 64, PWM frame length in clocks (multiple of 4, ≥4).
- WD_BASE_CYCLES, 1000, watchdog unit; limit = WD_BASE_CYCLES*(wd_code+1) clocks.

Ports:
- CLK_IN  in  1  system clock.
- RST_N_IN  in  1  asynchronous, active-low reset.
- SCAN_ACTIVE_IN  in  1  high while the decoder is in its scan phase.
- POLARITY_IN  in  1  1 = positive (SendPos), 0 = negative (SendNeg); meaningful only with SCAN_ACTIVE_IN=1.
- CONFIG_IN  in  4  metadata word: [1:0] amplitude code, [3:2] watchdog code.
- CONFIG_VALID_IN  in  1  one-cycle strobe, CONFIG_IN valid.
- HS_P_OUT  out  1  high-side gate, P leg.
- LS_P_OUT  out  1  low-side gate, P leg.
- HS_N_OUT  out  1  high-side gate, N leg.
- LS_N_OUT  out  1  low-side gate, N leg.
- DRIVE_BUSY_OUT  out  1  high in any state other than IDLE.
- FAULT_OUT  out  1  high in FAULT.

Behaviour:
- Reset and default values:
  - Async reset (RST_N_IN=0): all gate outputs 0, DRIVE_BUSY_OUT=0, FAULT_OUT=0, state IDLE, config register 4'b0000, all counters 0.
  - All outputs are registered.
- Config latch:
  - CONFIG_IN is captured on CONFIG_VALID_IN only while in IDLE. It is ignored in any other state.
  - Duty = (amp+1)*PWM_PERIOD/4 clocks. Default 64 gives 16/32/48/64; code 3 = 100%.
- States: IDLE, DEAD, DRIVE_POS, DRIVE_NEG, FAULT.
- IDLE:
  - All gates off.
  - SCAN_ACTIVE_IN=1 → DEAD, with dead counter cleared.
- DEAD:
  - All gates off for exactly DEAD_CYCLES clocks.
  - At exit, POLARITY_IN is sampled: 1 → DRIVE_POS, 0 → DRIVE_NEG.
  - A polarity change during DEAD does not restart the counter; only the value at exit matters.
- DRIVE_POS:
  - LS_N_OUT=1.
  - HS_P_OUT=1 while pwm_cnt < duty.
  - HS_N_OUT=0, LS_P_OUT=0.
- DRIVE_NEG: mirror of DRIVE_POS (LS_P_OUT=1, HS_N_OUT PWM'd).
- On entering either drive state: pwm_cnt=0 and wd_cnt=0, so the first drive clock has HS on for any duty.
- pwm_cnt wraps PWM_PERIOD-1 → 0.
- Direction change: POLARITY_IN differing from the current drive state → DEAD. Same polarity → stay, no dead time.
- Watchdog:
  - wd_cnt increments each drive clock.
  - wd_cnt reaching the limit → FAULT, with gates off on that same transition.
- FAULT:
  - All gates off; FAULT_OUT=1 (sticky).
  - Left only when SCAN_ACTIVE_IN=0, then → IDLE.
- Priority, highest first:
  1. SCAN_ACTIVE_IN=0 in DEAD or DRIVE_* → IDLE (all gates off next clock).
  2. Watchdog expiry.
  3. Polarity change.
- Latency: SCAN_ACTIVE_IN rise (POLARITY_IN=1) → HS_P_OUT/LS_N_OUT high after 1 + DEAD_CYCLES clocks.
- Safety invariants, asserted in the bench:
  - Never HS_P&LS_P, HS_N&LS_N, or HS_P&HS_N.
  - Any drive output pattern change across legs is separated by ≥ DEAD_CYCLES all-off clocks.
- Widths:
  - Dead counter is $clog2(DEAD_CYCLES+1) bits.
  - PWM counter is $clog2(PWM_PERIOD) bits.
  - Watchdog counter is $clog2(4*WD_BASE_CYCLES+1) bits; saturation is not needed because expiry exits the state.

Decomposition:
- Shared package coil_pkg: state enum (IDLE/DEAD/DRIVE_POS/DRIVE_NEG/FAULT), CONFIG field bit positions, amplitude/watchdog code widths. The decoder FSM imports the same field positions.
- One natural sub-module: coil_pwm_gen (free-running counter + compare, clear input, outputs pwm_on).

Test Plan:
- Reset mid-drive: in DRIVE_POS, assert RST_N_IN=0 → all four gates 0 in the same cycle (async), FAULT_OUT=0, config reads 0.
- Basic drive: config 4'b0011 latched in IDLE, SCAN_ACTIVE_IN=1, POLARITY_IN=1 → 8 all-off clocks, then LS_N_OUT=1 and HS_P_OUT=1 continuously (100% duty).
- PWM duty: amp=1, defaults → HS_P_OUT high 32 of every 64 clocks, first drive clock high, LS_N_OUT constant 1.
- Direction change: toggle POLARITY_IN 1→0 in DRIVE_POS → exactly 8 all-off clocks, then LS_P_OUT=1 and HS_N_OUT PWM; toggle again during DEAD → outcome follows the value at DEAD exit; no invariant violation.
- Watchdog: wd_code=0, WD_BASE_CYCLES=1000, hold POLARITY_IN=1 → FAULT at drive clock 1000, gates off, FAULT_OUT=1; still 1 with SCAN_ACTIVE_IN=1; SCAN_ACTIVE_IN=0 → IDLE, FAULT_OUT=0.
- Config gating: CONFIG_VALID_IN pulse with 4'b1111 during DRIVE_POS → ignored, duty unchanged; same pulse in IDLE → latched.
